// File: rtl/p_bit_tm_engine.sv
// Time-multiplexed p-bit engine: one scale/saturate/compare datapath plus one LFSR shared by
// N_PBITS p-bits. Optional flip counter output enabled by defining PBIT_TM_FLIP_CNT_EN.
module p_bit_tm_engine #(
  parameter int unsigned N_PBITS   = 16,
  parameter int unsigned IDX_W     = $clog2(N_PBITS),
  parameter int unsigned IN_W      = 8,
  parameter int unsigned BETA_W    = 4,
  parameter int unsigned BETA_FRAC = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               seed_load_i,
  input  logic [31:0]        seed_i,
  input  logic [BETA_W-1:0]  beta_i,
  input  logic               freeze_i,
  input  logic               clear_i,
  input  logic               upd_valid_i,
  output logic               upd_ready_o,
  input  logic [IDX_W-1:0]   upd_idx_i,
  input  logic [IN_W-1:0]    upd_in_i,
  output logic               out_valid_o,
  output logic [IDX_W-1:0]   out_idx_o,
  output logic               out_m_o,
  output logic [N_PBITS-1:0] m_vec_o,
  output logic               sweep_done_o,
`ifdef PBIT_TM_FLIP_CNT_EN
  output logic [31:0]        flip_cnt_o,
`endif
  output logic [15:0]        sweep_cnt_o
);

  localparam int unsigned ProdW = IN_W + BETA_W + 1;
  localparam logic signed [ProdW-1:0] PMax = ProdW'((2 ** (IN_W - 1)) - 1);
  localparam logic signed [ProdW-1:0] PMin = ProdW'(-(2 ** (IN_W - 1)));
  localparam logic [IN_W-1:0]  Bias     = {1'b1, {(IN_W - 1){1'b0}}};
  localparam logic [31:0]      LfsrMask = 32'h8020_0003;
  localparam logic [IDX_W:0]   NumPbits = (IDX_W + 1)'(N_PBITS);
  localparam logic [IDX_W-1:0] LastCnt  = IDX_W'(N_PBITS - 1);

  logic                    accept;
  logic signed [ProdW-1:0] prod, prod_sh;
  logic [IN_W-1:0]         p_sat;

  logic                    s1_valid_q, s1_valid_d, s1_ok_q, s1_ok_d;
  logic [IDX_W-1:0]        s1_idx_q, s1_idx_d;
  logic [IN_W-1:0]         s1_p_q, s1_p_d;

  logic [31:0]             lfsr_q, lfsr_d, lfsr_step;
  logic [N_PBITS-1:0]      m_vec_q, m_vec_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d, out_m_q, out_m_d;
  logic [IDX_W-1:0]        out_idx_q, out_idx_d;
  logic                    sweep_done_q, sweep_done_d;
  logic [15:0]             sweep_cnt_q, sweep_cnt_d;

  logic                    wr_en, m_new;
  logic [IN_W-1:0]         u, r;

  // Stage 1: scale by beta, arithmetic shift, saturate to the signed input range.
  always_comb begin
    upd_ready_o = !freeze_i && !clear_i;
    accept      = upd_valid_i && upd_ready_o;
    prod        = ProdW'($signed(upd_in_i)) * ProdW'($signed({1'b0, beta_i}));
    prod_sh     = prod >>> BETA_FRAC;
    if (prod_sh > PMax) begin
      p_sat = PMax[IN_W-1:0];
    end else if (prod_sh < PMin) begin
      p_sat = PMin[IN_W-1:0];
    end else begin
      p_sat = prod_sh[IN_W-1:0];
    end
    s1_valid_d = accept;
    s1_ok_d    = accept ? ({1'b0, upd_idx_i} < NumPbits) : s1_ok_q;
    s1_idx_d   = accept ? upd_idx_i : s1_idx_q;
    s1_p_d     = accept ? p_sat : s1_p_q;
  end

  // Stage 2: offset to unsigned and compare against the LFSR's top bits.
  always_comb begin
    wr_en     = s1_valid_q && s1_ok_q && !clear_i;
    u         = s1_p_q ^ Bias;
    r         = lfsr_q[31 -: IN_W];
    m_new     = u > r;
    lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrMask : 32'h0);

    m_vec_d      = m_vec_q;
    cnt_d        = cnt_q;
    lfsr_d       = lfsr_q;
    out_valid_d  = 1'b0;
    out_idx_d    = out_idx_q;
    out_m_d      = out_m_q;
    sweep_done_d = 1'b0;
    sweep_cnt_d  = sweep_cnt_q;

    if (wr_en) begin
      m_vec_d[s1_idx_q] = m_new;
      out_valid_d       = 1'b1;
      out_idx_d         = s1_idx_q;
      out_m_d           = m_new;
      lfsr_d            = lfsr_step;
      if (cnt_q == LastCnt) begin
        cnt_d        = '0;
        sweep_done_d = 1'b1;
        sweep_cnt_d  = sweep_cnt_q + 16'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // A same-cycle seed load wins over the step; the compare above already used the old value.
    if (seed_load_i) begin
      lfsr_d = (seed_i == 32'h0) ? 32'h1 : seed_i;
    end
    if (clear_i) begin
      m_vec_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q   <= 1'b0;
      s1_ok_q      <= 1'b0;
      s1_idx_q     <= '0;
      s1_p_q       <= '0;
      lfsr_q       <= 32'h1;
      m_vec_q      <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_m_q      <= 1'b0;
      sweep_done_q <= 1'b0;
      sweep_cnt_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_ok_q      <= s1_ok_d;
      s1_idx_q     <= s1_idx_d;
      s1_p_q       <= s1_p_d;
      lfsr_q       <= lfsr_d;
      m_vec_q      <= m_vec_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_m_q      <= out_m_d;
      sweep_done_q <= sweep_done_d;
      sweep_cnt_q  <= sweep_cnt_d;
    end
  end

`ifdef PBIT_TM_FLIP_CNT_EN
  logic [31:0] flip_q, flip_d;

  always_comb begin
    flip_d = flip_q;
    if (wr_en && (m_new != m_vec_q[s1_idx_q]) && (flip_q != 32'hFFFF_FFFF)) begin
      flip_d = flip_q + 32'd1;
    end
    if (clear_i) begin
      flip_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flip_q <= '0;
    end else begin
      flip_q <= flip_d;
    end
  end

  assign flip_cnt_o = flip_q;
`endif

  assign out_valid_o  = out_valid_q;
  assign out_idx_o    = out_idx_q;
  assign out_m_o      = out_m_q;
  assign m_vec_o      = m_vec_q;
  assign sweep_done_o = sweep_done_q;
  assign sweep_cnt_o  = sweep_cnt_q;

endmodule

// File: tb/tb_p_bit_tm_engine.sv
// Randomized self-checking bench for p_bit_tm_engine against an arithmetic reference model.
// Uses N_PBITS=12 so that out-of-range indices (12..15) are reachable on the 4-bit index port.
module tb_p_bit_tm_engine;
  localparam int NP = 12;
  localparam int IW = $clog2(NP);

  logic          clk = 1'b0;
  logic          rst_n, seed_load, freeze, clear, upd_valid;
  logic [31:0]   seed;
  logic [3:0]    beta;
  logic [IW-1:0] upd_idx;
  logic [7:0]    upd_in;
  logic          upd_ready, out_valid, out_m, sweep_done;
  logic [IW-1:0] out_idx;
  logic [NP-1:0] m_vec;
  logic [15:0]   sweep_cnt;
`ifdef PBIT_TM_FLIP_CNT_EN
  logic [31:0]   flip_cnt;
`endif

  always #5 clk = ~clk;

  p_bit_tm_engine #(.N_PBITS(NP)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .seed_load_i (seed_load),
    .seed_i      (seed),
    .beta_i      (beta),
    .freeze_i    (freeze),
    .clear_i     (clear),
    .upd_valid_i (upd_valid),
    .upd_ready_o (upd_ready),
    .upd_idx_i   (upd_idx),
    .upd_in_i    (upd_in),
    .out_valid_o (out_valid),
    .out_idx_o   (out_idx),
    .out_m_o     (out_m),
    .m_vec_o     (m_vec),
    .sweep_done_o(sweep_done),
`ifdef PBIT_TM_FLIP_CNT_EN
    .flip_cnt_o  (flip_cnt),
`endif
    .sweep_cnt_o (sweep_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: state of every p-bit, the generator value, and accepted-but-unwritten work.
  logic [31:0] mdl_lfsr;
  bit          mdl_m[NP];
  int          mdl_cnt;
  logic [15:0] mdl_sweeps;
  bit          mdl_ov, mdl_om, mdl_sd;
  int          mdl_oidx;
  longint      mdl_flips;
  bit          pend_v, pend_ok;
  int          pend_idx, pend_p;

  // Observed DUT activity.
  int dut_ov, dut_ones, dut_sd;
  bit rec_on;
  bit rec_q[$];

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic model_reset();
    mdl_lfsr = 32'h1;
    foreach (mdl_m[i]) mdl_m[i] = 1'b0;
    mdl_cnt = 0; mdl_sweeps = '0; mdl_flips = 0;
    mdl_ov = 0; mdl_om = 0; mdl_sd = 0; mdl_oidx = 0;
    pend_v = 0; pend_ok = 0; pend_idx = 0; pend_p = 0;
  endtask

  task automatic model_edge();
    int r, prod, ival;
    bit m;
    if (!rst_n) begin
      model_reset();
      return;
    end
    mdl_ov = 0;
    mdl_sd = 0;
    if (pend_v && pend_ok && !clear) begin
      r = int'(mdl_lfsr >> 24);
      m = ((pend_p + 128) > r);
      if (m != mdl_m[pend_idx]) mdl_flips++;
      mdl_m[pend_idx] = m;
      mdl_ov = 1; mdl_om = m; mdl_oidx = pend_idx;
      mdl_lfsr = lfsr_next(mdl_lfsr);
      mdl_cnt++;
      if (mdl_cnt == NP) begin
        mdl_cnt = 0; mdl_sd = 1; mdl_sweeps++;
      end
    end
    if (seed_load) mdl_lfsr = (seed == 0) ? 32'h1 : seed;
    if (clear) begin
      foreach (mdl_m[i]) mdl_m[i] = 1'b0;
      mdl_cnt = 0; mdl_flips = 0;
    end
    if (upd_valid && !freeze && !clear) begin
      ival = int'($signed(upd_in));
      prod = ival * int'(beta);
      pend_p = prod >>> 2;
      if (pend_p > 127) pend_p = 127;
      if (pend_p < -128) pend_p = -128;
      pend_v = 1; pend_idx = int'(upd_idx); pend_ok = (int'(upd_idx) < NP);
    end else begin
      pend_v = 0;
    end
  endtask

  task automatic compare_all();
    logic [NP-1:0] exp_vec;
    foreach (mdl_m[i]) exp_vec[i] = mdl_m[i];
    check_eq("upd_ready", 64'(upd_ready), 64'(!freeze && !clear));
    check_eq("out_valid", 64'(out_valid), 64'(mdl_ov));
    check_eq("out_idx", 64'(out_idx), 64'(mdl_oidx));
    check_eq("out_m", 64'(out_m), 64'(mdl_om));
    check_eq("m_vec", 64'(m_vec), 64'(exp_vec));
    check_eq("sweep_done", 64'(sweep_done), 64'(mdl_sd));
    check_eq("sweep_cnt", 64'(sweep_cnt), 64'(mdl_sweeps));
`ifdef PBIT_TM_FLIP_CNT_EN
    check_eq("flip_cnt", 64'(flip_cnt), 64'(mdl_flips));
`endif
    if (out_valid) begin
      dut_ov++;
      dut_ones += int'(out_m);
      if (rec_on) rec_q.push_back(out_m);
    end
    if (sweep_done) dut_sd++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit v, input int idx, input int i_val, input int b);
    upd_valid = v;
    upd_idx   = IW'(idx);
    upd_in    = 8'(i_val);
    beta      = 4'(b);
  endtask

  task automatic idle();
    seed_load = 0; clear = 0; freeze = 0;
    drive(0, 0, 0, 0);
  endtask

  task automatic reset_obs();
    dut_ov = 0; dut_ones = 0; dut_sd = 0;
  endtask

  int stim_idx[40], stim_in[40], stim_beta[40];
  bit run1[$];
  logic [31:0] det_seed;

  initial begin
    rst_n = 0; seed = '0;
    idle();
    model_reset();
    #1 compare_all();
    @(negedge clk);
    cycle();
    rst_n = 1;
    cycle();

    // Seed 0 maps to 1; idx 3 with I=-128 must produce 0 two cycles after it is presented.
    seed_load = 1; seed = 32'h0;
    cycle();
    seed_load = 0;
    drive(1, 3, -128, 4);
    cycle();
    check_eq("dir_ov_early", 64'(out_valid), 64'd0);
    drive(0, 0, 0, 0);
    cycle();
    check_eq("dir_ov", 64'(out_valid), 64'd1);
    check_eq("dir_idx", 64'(out_idx), 64'd3);
    check_eq("dir_m", 64'(out_m), 64'd0);
    check_eq("dir_vec", 64'(m_vec), 64'd0);

    // Random traffic including freeze, clear, seed loads and out-of-range indices.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 15), $urandom_range(0, 255),
            $urandom_range(0, 15));
      freeze    = ($urandom_range(0, 9) == 0);
      clear     = ($urandom_range(0, 29) == 0);
      seed_load = ($urandom_range(0, 29) == 0);
      seed      = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      cycle();
    end
    idle();
    cycle(); cycle();

    // I=0: p=0, u=128, so roughly half of the writes give 1.
    reset_obs();
    for (int n = 0; n < 10000; n++) begin
      drive(1, n % NP, 0, 4);
      cycle();
    end
    drive(0, 0, 0, 0);
    cycle(); cycle();
    check_eq("half_count", 64'(dut_ov), 64'd10000);
    check_eq("half_frac", 64'(dut_ones * 100 >= dut_ov * 48 && dut_ones * 100 <= dut_ov * 52),
             64'd1);

    // Saturated high inputs: nearly always 1.
    foreach (stim_in[k]) stim_in[k] = 0;
    for (int pass = 0; pass < 2; pass++) begin
      reset_obs();
      for (int n = 0; n < 2000; n++) begin
        drive(1, n % NP, (pass == 0) ? 127 : 100, 15);
        cycle();
      end
      drive(0, 0, 0, 0);
      cycle(); cycle();
      check_eq("sat_hi_frac", 64'(dut_ones * 100 >= dut_ov * 99), 64'd1);
    end

    // I=-100 saturates to -128: u=0 can never exceed r.
    reset_obs();
    for (int n = 0; n < 500; n++) begin
      drive(1, n % NP, -100, 15);
      cycle();
    end
    drive(0, 0, 0, 0);
    cycle(); cycle();
    check_eq("sat_lo_ones", 64'(dut_ones), 64'd0);
    check_eq("sat_lo_count", 64'(dut_ov), 64'd500);

    // Freeze with valid high: only the already-accepted two updates come out.
    reset_obs();
    drive(1, 1, 50, 4); cycle();
    drive(1, 2, 50, 4); cycle();
    freeze = 1;
    for (int n = 0; n < 5; n++) begin
      cycle();
      check_eq("frz_ready", 64'(upd_ready), 64'd0);
    end
    freeze = 0; drive(0, 0, 0, 0);
    cycle();
    check_eq("frz_out_cnt", 64'(dut_ov), 64'd2);

    // Leave the sweep counter mid-way, then clear with updates pending.
    for (int n = 0; n < 5; n++) begin
      drive(1, n, 90, 8);
      cycle();
    end
    drive(0, 0, 0, 0);
    clear = 1;
    reset_obs();
    cycle();
    clear = 0;
    check_eq("clr_ov", 64'(out_valid), 64'd0);
    check_eq("clr_vec", 64'(m_vec), 64'd0);
    cycle(); cycle();
    check_eq("clr_no_out", 64'(dut_ov), 64'd0);

    // Full sweep from a cleared counter, then one out-of-range index.
    reset_obs();
    for (int n = 0; n < NP; n++) begin
      drive(1, n, $urandom_range(0, 255), $urandom_range(0, 15));
      cycle();
      if (out_valid && dut_ov == NP) check_eq("sweep_coinc", 64'(sweep_done), 64'd1);
    end
    drive(1, 13, 127, 15);
    cycle();
    drive(0, 0, 0, 0);
    for (int n = 0; n < 4; n++) begin
      cycle();
      if (out_valid && dut_ov == NP) check_eq("sweep_coinc", 64'(sweep_done), 64'd1);
    end
    check_eq("sweep_pulses", 64'(dut_sd), 64'd1);
    check_eq("sweep_writes", 64'(dut_ov), 64'(NP));

    // Same seed plus same stimulus must reproduce the output sequence exactly.
    det_seed = $urandom | 32'h1;
    foreach (stim_idx[k]) begin
      stim_idx[k]  = $urandom_range(0, 15);
      stim_in[k]   = $urandom_range(0, 255);
      stim_beta[k] = $urandom_range(0, 15);
    end
    for (int pass = 0; pass < 2; pass++) begin
      rec_q.delete();
      seed_load = 1; seed = det_seed; clear = 1;
      cycle();
      seed_load = 0; clear = 0;
      rec_on = 1;
      foreach (stim_idx[k]) begin
        drive(1, stim_idx[k], stim_in[k], stim_beta[k]);
        cycle();
      end
      drive(0, 0, 0, 0);
      cycle(); cycle();
      rec_on = 0;
      if (pass == 0) run1 = rec_q;
    end
    check_eq("det_len", 64'(rec_q.size()), 64'(run1.size()));
    for (int k = 0; k < run1.size() && k < rec_q.size(); k++)
      check_eq("det_bit", 64'(rec_q[k]), 64'(run1[k]));

    // Seed load coinciding with a write: the model covers old-value compare and new next compare.
    drive(1, 4, 10, 6); cycle();
    drive(1, 5, 10, 6); seed_load = 1; seed = 32'hDEAD_BEEF; cycle();
    seed_load = 0; drive(1, 6, -5, 6); cycle();
    drive(0, 0, 0, 0); cycle(); cycle();

    // Asynchronous reset in the middle of a stream.
    drive(1, 7, 60, 9); cycle();
    drive(1, 8, 60, 9); cycle();
    rst_n = 0;
    #1;
    model_reset();
    compare_all();
    check_eq("rst_vec", 64'(m_vec), 64'd0);
    check_eq("rst_cnt", 64'(sweep_cnt), 64'd0);
    cycle();
    @(negedge clk);
    rst_n = 1;
    drive(0, 0, 0, 0);
    for (int n = 0; n < 4; n++) cycle();
    check_eq("rst_ov", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
